// File: rtl/pri_arb_n.sv
// N-way priority arbiter (fixed or round-robin) with registered one-hot grant held until done.
// Latency: 1 edge from req or done to grant. No backpressure: owner holds the resource until done.
module pri_arb_n #(
    parameter int N     = 4,
    parameter int IDX_W = 2,
    parameter bit RR    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [IDX_W-1:0] search_base;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [N-1:0]     grant_nxt;
    logic [IDX_W-1:0] grant_idx_nxt;
    logic             valid_nxt;

    // Fixed mode is the round-robin search anchored at 0: order N-1 down to 0.
    assign search_base = RR ? last : '0;

    // Walk from the lowest-priority offset to the highest so the last hit wins.
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        for (int off = N; off >= 1; off--) begin
            int cand;
            cand = int'(search_base) + N - off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[IDX_W'(cand)]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
        valid_nxt     = valid;
        last_nxt      = last;
        if (state == IDLE || done) begin
            if (win_any) begin
                state_nxt          = OWNED;
                grant_nxt          = '0;
                grant_nxt[win_idx] = 1'b1;
                grant_idx_nxt      = win_idx;
                valid_nxt          = 1'b1;
                last_nxt           = win_idx;
            end else begin
                state_nxt     = IDLE;
                grant_nxt     = '0;
                grant_idx_nxt = '0;
                valid_nxt     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            valid     <= 1'b0;
            last      <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= grant_idx_nxt;
            valid     <= valid_nxt;
            last      <= last_nxt;
        end
    end

endmodule

// File: tb/tb_pri_arb_n.sv
// Directed bench for pri_arb_n: one fixed-priority and one round-robin instance on a shared clock/reset.
module tb_pri_arb_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_f, req_r;
    logic       done_f, done_r;
    logic [3:0] grant_f, grant_r;
    logic [1:0] idx_f, idx_r;
    logic       valid_f, valid_r;
    logic [6:0] obs;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    pri_arb_n #(.N(4), .IDX_W(2), .RR(1'b0)) u_fix (
        .clk(clk), .rst(rst), .req(req_f), .done(done_f),
        .grant(grant_f), .grant_idx(idx_f), .valid(valid_f)
    );

    pri_arb_n #(.N(4), .IDX_W(2), .RR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .req(req_r), .done(done_r),
        .grant(grant_r), .grant_idx(idx_r), .valid(valid_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_f = 4'b1111; req_r = 4'b1111; done_f = 1'b1; done_r = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = {grant_f, idx_f, valid_f}; checks++;
            if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL reset_fix cyc=%0d got=%b exp=%b", c, obs, 7'b0000_00_0); end
            obs = {grant_r, idx_r, valid_r}; checks++;
            if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL reset_rr cyc=%0d got=%b exp=%b", c, obs, 7'b0000_00_0); end
        end
        rst = 1'b0; done_f = 1'b0; req_r = 4'b0000; done_r = 1'b1;
        step();
        obs = {grant_f, idx_f, valid_f}; checks++;
        if (obs !== 7'b1000_11_1) begin errors++; $display("FAIL first_grant got=%b exp=%b", obs, 7'b1000_11_1); end
        obs = {grant_r, idx_r, valid_r}; checks++;
        if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL rr_idle_done got=%b exp=%b", obs, 7'b0000_00_0); end
        req_f = 4'b0000; done_f = 1'b1;
        step();
        obs = {grant_f, idx_f, valid_f}; checks++;
        if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL release_to_idle got=%b exp=%b", obs, 7'b0000_00_0); end
    endtask

    task automatic test_idle_done();
        req_f = 4'b0000; done_f = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            obs = {grant_f, idx_f, valid_f}; checks++;
            if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL idle_done cyc=%0d got=%b exp=%b", c, obs, 7'b0000_00_0); end
        end
        done_f = 1'b0;
    endtask

    task automatic test_fixed_hold();
        req_f = 4'b0101; done_f = 1'b0;
        step();
        obs = {grant_f, idx_f, valid_f}; checks++;
        if (obs !== 7'b0100_10_1) begin errors++; $display("FAIL fix_load got=%b exp=%b", obs, 7'b0100_10_1); end
        req_f = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            step();
            obs = {grant_f, idx_f, valid_f}; checks++;
            if (obs !== 7'b0100_10_1) begin errors++; $display("FAIL fix_hold cyc=%0d got=%b exp=%b", c, obs, 7'b0100_10_1); end
        end
        req_f = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = {grant_f, idx_f, valid_f}; checks++;
            if (obs !== 7'b0100_10_1) begin errors++; $display("FAIL fix_hold_noreq cyc=%0d got=%b exp=%b", c, obs, 7'b0100_10_1); end
        end
        req_f = 4'b1011; done_f = 1'b1;
        step();
        obs = {grant_f, idx_f, valid_f}; checks++;
        if (obs !== 7'b1000_11_1) begin errors++; $display("FAIL fix_handoff got=%b exp=%b", obs, 7'b1000_11_1); end
        req_f = 4'b0000;
        step();
        obs = {grant_f, idx_f, valid_f}; checks++;
        if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL fix_done_noreq got=%b exp=%b", obs, 7'b0000_00_0); end
        done_f = 1'b0;
    endtask

    task automatic test_starvation();
        req_f = 4'b1111; done_f = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            obs = {grant_f, idx_f, valid_f}; checks++;
            if (obs !== 7'b1000_11_1) begin errors++; $display("FAIL fix_starve cyc=%0d got=%b exp=%b", c, obs, 7'b1000_11_1); end
        end
        req_f = 4'b0000;
        step();
        done_f = 1'b0;
    endtask

    task automatic test_rr_rotate();
        logic [6:0] exp_seq [6];
        exp_seq[0] = 7'b1000_11_1;
        exp_seq[1] = 7'b0100_10_1;
        exp_seq[2] = 7'b0010_01_1;
        exp_seq[3] = 7'b0001_00_1;
        exp_seq[4] = 7'b1000_11_1;
        exp_seq[5] = 7'b0100_10_1;
        req_r = 4'b1111; done_r = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            obs = {grant_r, idx_r, valid_r}; checks++;
            if (obs !== exp_seq[c]) begin errors++; $display("FAIL rr_rotate cyc=%0d got=%b exp=%b", c, obs, exp_seq[c]); end
        end
    endtask

    task automatic test_rr_sparse();
        // Owner is 2 on entry.
        req_r = 4'b0101; done_r = 1'b1;
        step();
        obs = {grant_r, idx_r, valid_r}; checks++;
        if (obs !== 7'b0001_00_1) begin errors++; $display("FAIL rr_sparse_a got=%b exp=%b", obs, 7'b0001_00_1); end
        step();
        obs = {grant_r, idx_r, valid_r}; checks++;
        if (obs !== 7'b0100_10_1) begin errors++; $display("FAIL rr_sparse_wrap got=%b exp=%b", obs, 7'b0100_10_1); end
        done_r = 1'b0; req_r = 4'b1011;
        step();
        obs = {grant_r, idx_r, valid_r}; checks++;
        if (obs !== 7'b0100_10_1) begin errors++; $display("FAIL rr_hold got=%b exp=%b", obs, 7'b0100_10_1); end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1; req_r = 4'b1111; done_r = 1'b1; req_f = 4'b1111; done_f = 1'b1;
        step();
        obs = {grant_r, idx_r, valid_r}; checks++;
        if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL rst_mid_rr got=%b exp=%b", obs, 7'b0000_00_0); end
        obs = {grant_f, idx_f, valid_f}; checks++;
        if (obs !== 7'b0000_00_0) begin errors++; $display("FAIL rst_mid_fix got=%b exp=%b", obs, 7'b0000_00_0); end
        rst = 1'b0; req_r = 4'b0011; done_r = 1'b0; req_f = 4'b0000; done_f = 1'b0;
        step();
        obs = {grant_r, idx_r, valid_r}; checks++;
        if (obs !== 7'b0010_01_1) begin errors++; $display("FAIL rr_ptr_reset got=%b exp=%b", obs, 7'b0010_01_1); end
        req_r = 4'b0011; done_r = 1'b1;
        step();
        obs = {grant_r, idx_r, valid_r}; checks++;
        if (obs !== 7'b0001_00_1) begin errors++; $display("FAIL rr_after_reset got=%b exp=%b", obs, 7'b0001_00_1); end
    endtask

    initial begin
        rst = 1'b1; req_f = '0; req_r = '0; done_f = 1'b0; done_r = 1'b0;
        #2;
        test_reset();
        test_idle_done();
        test_fixed_hold();
        test_starvation();
        test_rr_rotate();
        test_rr_sparse();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pri_arb_n.md
# pri_arb_n

Parametrised N-requester priority arbiter with registered, one-hot grant and a release handshake. It is the sequential successor to the 4-to-2 priority encoder. It encodes the winning request, as the encoder does, and also holds ownership across cycles. It offers fixed or round-robin priority. It sits in front of any shared resource (bus, memory port, output channel) that several requesters contend for.

## Interface
Parameters:
- N, 4, number of requesters; legal range 2..32
- IDX_W, 2, width of grant_idx; must equal ceil(log2(N))
- RR, 0, priority mode: 0 = fixed (highest index wins), 1 = round-robin

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  N  request vector; bit i = requester i wants the resource
- done  input  1  current owner releases the resource; sampled only while valid=1
- grant  output  N  one-hot grant to the current owner; all zero when idle
- grant_idx  output  IDX_W  binary index of the current owner; 0 when idle
- valid  output  1  a grant is active (equals |grant)

## Operation
- FSM with two states:
  - IDLE: grant=0, valid=0. On an edge with |req=1, select a winner from req, load grant/grant_idx, set valid, go to OWNED.
  - OWNED: grant, grant_idx and valid are frozen regardless of req changes, including the owner dropping its req bit. On an edge with done=1, re-arbitrate over req sampled on that same edge:
    - if any bit is set, load the new winner and stay in OWNED (back-to-back handoff, no idle cycle);
    - else clear the outputs and go to IDLE.
- Fixed mode (RR=0): winner = highest set index. Lower requesters may starve; this is intended.
- Round-robin mode (RR=1):
  - A last-owner register `last` is updated on every load.
  - Search order is last-1, last-2, …, 0, N-1, …, last, descending with wrap-around.
  - The previous owner therefore has lowest priority at handoff.
  - `last` resets to 0, so the first search starts at N-1 and the first grant matches fixed mode.
- done is ignored in IDLE. done=1 with req=0 in OWNED → IDLE.
- grant is always one-hot or zero. grant_idx always equals the encoded grant.
- Reset clears grant=0, grant_idx=0, valid=0, state=IDLE, last=0.
  - rst dominates req and done on the same edge.
  - Reset mid-ownership drops the grant at that edge, with no handoff.
- Arbitration logic is combinational over req and last, with a loop or mask-and-select over N. There is no width-dependent special casing beyond IDX_W.

## Timing
- Request-to-grant latency: 1 edge. req is sampled at edge k; grant is visible after edge k.
- Handoff latency: 1 edge. done=1 is sampled at edge k; the new owner's grant (or zero) is visible after edge k.
- Minimum ownership: 1 cycle. done may be asserted in the first cycle grant is visible.
- All outputs are registered; there is no combinational path from req or done to outputs.
- Throughput: one grant change per cycle at most.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=1111 and done=1 → grant=0000, grant_idx=0, valid=0 throughout. After release, the first edge with req=1111 gives grant=1000 and grant_idx=3.
- Fixed, hold (N=4, RR=0):
  - req=0101 at edge → grant=0100, grant_idx=2, valid=1.
  - Change req to 1011 with no done → grant stays 0100 for 5 cycles.
  - done=1 → grant=1000 next edge.
- Fixed, starvation (RR=0): req=1111 constant, done=1 every cycle → grant=1000 on every edge; bits 0..2 never granted.
- Round-robin (RR=1): req=1111 constant, done=1 every cycle → grants 1000, 0100, 0010, 0001, 1000, with grant_idx 3, 2, 1, 0, 3.
- Round-robin, sparse (RR=1): after owner 2, req=0101 with done → grant=0001. Next done with req=0101 → grant=0100 (wrap-around skips empty indices).
- Boundaries:
  - done=1 in IDLE with req=0 → no change.
  - done=1 with req=0000 in OWNED → grant=0000, valid=0 next edge.
  - rst=1 while owned with done=1 and req=1111 → outputs 0. Afterwards in RR mode, req=0011 → grant=0010 (pointer reset).
